// File: rtl/decode_queue_pkg.sv
// Shared constants and types for the decode queue: opcodes, instruction-name codes, decoded entry.
// Name codes 38..45 are decoded only when DECODE_RV32M_EN is defined.
package decode_queue_pkg;

    localparam int NAME_W = 6;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [NAME_W-1:0] {
        NAME_NONE = 6'd0,
        NAME_LUI, NAME_AUIPC, NAME_JAL, NAME_JALR,
        NAME_BEQ, NAME_BNE, NAME_BLT, NAME_BGE, NAME_BLTU, NAME_BGEU,
        NAME_LB, NAME_LH, NAME_LW, NAME_LBU, NAME_LHU,
        NAME_SB, NAME_SH, NAME_SW,
        NAME_ADDI, NAME_SLTI, NAME_SLTIU, NAME_XORI, NAME_ORI, NAME_ANDI,
        NAME_SLLI, NAME_SRLI, NAME_SRAI,
        NAME_ADD, NAME_SUB, NAME_SLL, NAME_SLT, NAME_SLTU,
        NAME_XOR, NAME_SRL, NAME_SRA, NAME_OR, NAME_AND,
        NAME_MUL = 6'd38, NAME_MULH, NAME_MULHSU, NAME_MULHU,
        NAME_DIV, NAME_DIVU, NAME_REM, NAME_REMU
    } name_e;

    typedef struct packed {
        name_e       name;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/decode_queue_decode_comb.sv
// Combinational RV32I instruction decoder (RV32M added when DECODE_RV32M_EN is defined).
module decode_comb
    import decode_queue_pkg::*;
(
    input  logic [31:0] inst,
    output dec_t        dec
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd_f, rs1_f, rs2_f;
    logic [31:0] imm_i, imm_sh, imm_s, imm_b, imm_u, imm_j;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign rd_f   = inst[11:7];
    assign rs1_f  = inst[19:15];
    assign rs2_f  = inst[24:20];

    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_sh = {27'b0, inst[24:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves it unassigned (no latches).
        dec = '0;
        case (opcode)
            OP_LUI: begin
                dec.name = NAME_LUI;
                dec.rd   = rd_f;
                dec.imm  = imm_u;
            end
            OP_AUIPC: begin
                dec.name = NAME_AUIPC;
                dec.rd   = rd_f;
                dec.imm  = imm_u;
            end
            OP_JAL: begin
                dec.name = NAME_JAL;
                dec.rd   = rd_f;
                dec.imm  = imm_j;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) dec.name = NAME_JALR;
                dec.rd  = rd_f;
                dec.rs1 = rs1_f;
                dec.imm = imm_i;
            end
            OP_BRANCH: begin
                case (funct3)
                    3'b000:  dec.name = NAME_BEQ;
                    3'b001:  dec.name = NAME_BNE;
                    3'b100:  dec.name = NAME_BLT;
                    3'b101:  dec.name = NAME_BGE;
                    3'b110:  dec.name = NAME_BLTU;
                    3'b111:  dec.name = NAME_BGEU;
                    default: dec.name = NAME_NONE;
                endcase
                dec.rs1 = rs1_f;
                dec.rs2 = rs2_f;
                dec.imm = imm_b;
            end
            OP_LOAD: begin
                case (funct3)
                    3'b000:  dec.name = NAME_LB;
                    3'b001:  dec.name = NAME_LH;
                    3'b010:  dec.name = NAME_LW;
                    3'b100:  dec.name = NAME_LBU;
                    3'b101:  dec.name = NAME_LHU;
                    default: dec.name = NAME_NONE;
                endcase
                dec.rd  = rd_f;
                dec.rs1 = rs1_f;
                dec.imm = imm_i;
            end
            OP_STORE: begin
                case (funct3)
                    3'b000:  dec.name = NAME_SB;
                    3'b001:  dec.name = NAME_SH;
                    3'b010:  dec.name = NAME_SW;
                    default: dec.name = NAME_NONE;
                endcase
                dec.rs1 = rs1_f;
                dec.rs2 = rs2_f;
                dec.imm = imm_s;
            end
            OP_IMM: begin
                case (funct3)
                    3'b000:  dec.name = NAME_ADDI;
                    3'b010:  dec.name = NAME_SLTI;
                    3'b011:  dec.name = NAME_SLTIU;
                    3'b100:  dec.name = NAME_XORI;
                    3'b110:  dec.name = NAME_ORI;
                    3'b111:  dec.name = NAME_ANDI;
                    3'b001:  if (funct7 == F7_BASE) dec.name = NAME_SLLI;
                    3'b101: begin
                        if (funct7 == F7_BASE)     dec.name = NAME_SRLI;
                        else if (funct7 == F7_ALT) dec.name = NAME_SRAI;
                    end
                    default: dec.name = NAME_NONE;
                endcase
                dec.rd  = rd_f;
                dec.rs1 = rs1_f;
                // Shifts carry only the shamt; the funct7 bits are not part of the immediate.
                dec.imm = (funct3 == 3'b001 || funct3 == 3'b101) ? imm_sh : imm_i;
            end
            OP_REG: begin
                case (funct7)
                    F7_BASE: begin
                        case (funct3)
                            3'b000:  dec.name = NAME_ADD;
                            3'b001:  dec.name = NAME_SLL;
                            3'b010:  dec.name = NAME_SLT;
                            3'b011:  dec.name = NAME_SLTU;
                            3'b100:  dec.name = NAME_XOR;
                            3'b101:  dec.name = NAME_SRL;
                            3'b110:  dec.name = NAME_OR;
                            default: dec.name = NAME_AND;
                        endcase
                    end
                    F7_ALT: begin
                        if (funct3 == 3'b000)      dec.name = NAME_SUB;
                        else if (funct3 == 3'b101) dec.name = NAME_SRA;
                    end
`ifdef DECODE_RV32M_EN
                    F7_MULDIV: begin
                        case (funct3)
                            3'b000:  dec.name = NAME_MUL;
                            3'b001:  dec.name = NAME_MULH;
                            3'b010:  dec.name = NAME_MULHSU;
                            3'b011:  dec.name = NAME_MULHU;
                            3'b100:  dec.name = NAME_DIV;
                            3'b101:  dec.name = NAME_DIVU;
                            3'b110:  dec.name = NAME_REM;
                            default: dec.name = NAME_REMU;
                        endcase
                    end
`endif
                    default: dec.name = NAME_NONE;
                endcase
                dec.rd  = rd_f;
                dec.rs1 = rs1_f;
                dec.rs2 = rs2_f;
            end
            default: dec.name = NAME_NONE;
        endcase

        // Unrecognised encodings carry no operands so dispatch sees a clean exception entry.
        if (dec.name == NAME_NONE) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_queue.sv
// Decoded-instruction queue between fetch and dispatch; DEPTH-entry circular buffer.
// RV32M decode is enabled by defining DECODE_RV32M_EN.
module decode_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int NAME_W = 6
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              inst_valid,
    input  logic [31:0]       inst,
    input  logic [PC_W-1:0]   inst_pc,
    output logic              inst_ready,
    input  logic              dec_ready,
    output logic              dec_valid,
    output logic [NAME_W-1:0] dec_name,
    output logic [4:0]        dec_rd,
    output logic [4:0]        dec_rs1,
    output logic [4:0]        dec_rs2,
    output logic [31:0]       dec_imm,
    output logic [PC_W-1:0]   dec_pc,
    output logic              dec_illegal
);

    import decode_queue_pkg::*;

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    dec_t             dec_new;
    dec_t             ent_q [DEPTH];
    logic [PC_W-1:0]  pc_q  [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic [PTR_W:0]   count;
    logic             enq, deq;
    dec_t             head_ent;

    decode_comb u_decode (
        .inst (inst),
        .dec  (dec_new)
    );

    // Readiness depends on stored occupancy only, never on this cycle's dec_ready.
    assign inst_ready = (count != CNT_FULL);
    assign dec_valid  = (count != '0);
    assign enq        = inst_valid && inst_ready && rdy_in && !flush_in;
    assign deq        = dec_valid && dec_ready && rdy_in && !flush_in;

    assign head_ent    = ent_q[head];
    assign dec_name    = NAME_W'(head_ent.name);
    assign dec_rd      = head_ent.rd;
    assign dec_rs1     = head_ent.rs1;
    assign dec_rs2     = head_ent.rs2;
    assign dec_imm     = head_ent.imm;
    assign dec_illegal = head_ent.illegal;
    assign dec_pc      = pc_q[head];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            // NOTE: storage is reset too, so the head fields read as zero straight out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
                pc_q[i]  <= '0;
            end
        end else if (flush_in) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                ent_q[tail] <= dec_new;
                pc_q[tail]  <= inst_pc;
                tail        <= tail + PTR_ONE;
            end
            if (deq) begin
                head <= head + PTR_ONE;
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: directed plan steps plus randomized traffic vs a queue model.
// Define DECODE_RV32M_EN for both bench and RTL to check the RV32M build.
module tb_decode_queue;

    import decode_queue_pkg::*;

    localparam int DEPTH = 4;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in, inst_valid, dec_ready;
    logic [31:0] inst, inst_pc;
    logic        inst_ready, dec_valid, dec_illegal;
    logic [5:0]  dec_name;
    logic [4:0]  dec_rd, dec_rs1, dec_rs2;
    logic [31:0] dec_imm, dec_pc;

    int errors = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    decode_queue #(.DEPTH(DEPTH), .PC_W(32), .NAME_W(6)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .flush_in    (flush_in),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready),
        .dec_ready   (dec_ready),
        .dec_valid   (dec_valid),
        .dec_name    (dec_name),
        .dec_rd      (dec_rd),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_imm     (dec_imm),
        .dec_pc      (dec_pc),
        .dec_illegal (dec_illegal)
    );

    typedef enum {F_R, F_I, F_SH, F_S, F_B, F_U, F_J} fmt_e;

    typedef struct {
        logic [31:0] mask;
        logic [31:0] match;
        name_e       name;
        fmt_e        fmt;
    } pat_t;

    typedef struct {
        name_e       name;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
        logic [31:0] pc;
    } exp_t;

    pat_t pats[$];
    exp_t q[$];

    localparam logic [31:0] M_OPC = 32'h0000_007F;
    localparam logic [31:0] M_F3  = 32'h0000_707F;
    localparam logic [31:0] M_F7  = 32'hFE00_707F;

    function automatic void add_pat(input logic [31:0] mask, input logic [31:0] match,
                                    input name_e name, input fmt_e fmt);
        pat_t p;
        p.mask = mask; p.match = match; p.name = name; p.fmt = fmt;
        pats.push_back(p);
    endfunction

    // Encoding table in mask/match form, as in the ISA manual's opcode map.
    function automatic void build_table();
        add_pat(M_OPC, 32'h0000_0037, NAME_LUI,   F_U);
        add_pat(M_OPC, 32'h0000_0017, NAME_AUIPC, F_U);
        add_pat(M_OPC, 32'h0000_006F, NAME_JAL,   F_J);
        add_pat(M_F3,  32'h0000_0067, NAME_JALR,  F_I);
        add_pat(M_F3,  32'h0000_0063, NAME_BEQ,   F_B);
        add_pat(M_F3,  32'h0000_1063, NAME_BNE,   F_B);
        add_pat(M_F3,  32'h0000_4063, NAME_BLT,   F_B);
        add_pat(M_F3,  32'h0000_5063, NAME_BGE,   F_B);
        add_pat(M_F3,  32'h0000_6063, NAME_BLTU,  F_B);
        add_pat(M_F3,  32'h0000_7063, NAME_BGEU,  F_B);
        add_pat(M_F3,  32'h0000_0003, NAME_LB,    F_I);
        add_pat(M_F3,  32'h0000_1003, NAME_LH,    F_I);
        add_pat(M_F3,  32'h0000_2003, NAME_LW,    F_I);
        add_pat(M_F3,  32'h0000_4003, NAME_LBU,   F_I);
        add_pat(M_F3,  32'h0000_5003, NAME_LHU,   F_I);
        add_pat(M_F3,  32'h0000_0023, NAME_SB,    F_S);
        add_pat(M_F3,  32'h0000_1023, NAME_SH,    F_S);
        add_pat(M_F3,  32'h0000_2023, NAME_SW,    F_S);
        add_pat(M_F3,  32'h0000_0013, NAME_ADDI,  F_I);
        add_pat(M_F3,  32'h0000_2013, NAME_SLTI,  F_I);
        add_pat(M_F3,  32'h0000_3013, NAME_SLTIU, F_I);
        add_pat(M_F3,  32'h0000_4013, NAME_XORI,  F_I);
        add_pat(M_F3,  32'h0000_6013, NAME_ORI,   F_I);
        add_pat(M_F3,  32'h0000_7013, NAME_ANDI,  F_I);
        add_pat(M_F7,  32'h0000_1013, NAME_SLLI,  F_SH);
        add_pat(M_F7,  32'h0000_5013, NAME_SRLI,  F_SH);
        add_pat(M_F7,  32'h4000_5013, NAME_SRAI,  F_SH);
        add_pat(M_F7,  32'h0000_0033, NAME_ADD,   F_R);
        add_pat(M_F7,  32'h4000_0033, NAME_SUB,   F_R);
        add_pat(M_F7,  32'h0000_1033, NAME_SLL,   F_R);
        add_pat(M_F7,  32'h0000_2033, NAME_SLT,   F_R);
        add_pat(M_F7,  32'h0000_3033, NAME_SLTU,  F_R);
        add_pat(M_F7,  32'h0000_4033, NAME_XOR,   F_R);
        add_pat(M_F7,  32'h0000_5033, NAME_SRL,   F_R);
        add_pat(M_F7,  32'h4000_5033, NAME_SRA,   F_R);
        add_pat(M_F7,  32'h0000_6033, NAME_OR,    F_R);
        add_pat(M_F7,  32'h0000_7033, NAME_AND,   F_R);
`ifdef DECODE_RV32M_EN
        add_pat(M_F7,  32'h0200_0033, NAME_MUL,    F_R);
        add_pat(M_F7,  32'h0200_1033, NAME_MULH,   F_R);
        add_pat(M_F7,  32'h0200_2033, NAME_MULHSU, F_R);
        add_pat(M_F7,  32'h0200_3033, NAME_MULHU,  F_R);
        add_pat(M_F7,  32'h0200_4033, NAME_DIV,    F_R);
        add_pat(M_F7,  32'h0200_5033, NAME_DIVU,   F_R);
        add_pat(M_F7,  32'h0200_6033, NAME_REM,    F_R);
        add_pat(M_F7,  32'h0200_7033, NAME_REMU,   F_R);
`endif
    endfunction

    // Immediates computed arithmetically from the field weights, not by bit concatenation.
    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t e;
        int   idx = -1;
        int   imm = 0;
        e.name = NAME_NONE; e.rd = '0; e.rs1 = '0; e.rs2 = '0;
        e.imm = '0; e.illegal = 1'b0; e.pc = '0;
        foreach (pats[k]) if (idx < 0 && (w & pats[k].mask) == pats[k].match) idx = k;
        if (idx < 0) begin
            e.illegal = 1'b1;
            return e;
        end
        e.name = pats[idx].name;
        case (pats[idx].fmt)
            F_R:  begin e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; end
            F_I:  begin e.rd = w[11:7]; e.rs1 = w[19:15]; imm = $signed(w) >>> 20; end
            F_SH: begin e.rd = w[11:7]; e.rs1 = w[19:15]; imm = int'(w[24:20]); end
            F_S:  begin
                e.rs1 = w[19:15]; e.rs2 = w[24:20];
                imm = (($signed(w) >>> 25) * 32) + int'(w[11:7]);
            end
            F_B:  begin
                e.rs1 = w[19:15]; e.rs2 = w[24:20];
                imm = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                      + int'(w[11:8]) * 2;
            end
            F_U:  begin e.rd = w[11:7]; imm = int'(w & 32'hFFFF_F000); end
            default: begin
                e.rd = w[11:7];
                imm = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                      + int'(w[30:21]) * 2;
            end
        endcase
        e.imm = imm;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".inst_ready"}, 64'(inst_ready), 64'(q.size() != DEPTH));
        check({tag, ".dec_valid"},  64'(dec_valid),  64'(q.size() != 0));
        if (q.size() != 0) begin
            check({tag, ".name"},    64'(dec_name),    64'(q[0].name));
            check({tag, ".rd"},      64'(dec_rd),      64'(q[0].rd));
            check({tag, ".rs1"},     64'(dec_rs1),     64'(q[0].rs1));
            check({tag, ".rs2"},     64'(dec_rs2),     64'(q[0].rs2));
            check({tag, ".imm"},     64'(dec_imm),     64'(q[0].imm));
            check({tag, ".illegal"}, 64'(dec_illegal), 64'(q[0].illegal));
            check({tag, ".pc"},      64'(dec_pc),      64'(q[0].pc));
        end
    endtask

    // Drive one cycle of inputs (called at posedge+1), advance the model, then compare at posedge+1.
    task automatic step(input string tag, input logic v, input logic [31:0] w,
                        input logic [31:0] pc, input logic dr, input logic rdy, input logic fl);
        exp_t e;
        bit   full, empty;
        inst_valid = v; inst = w; inst_pc = pc;
        dec_ready = dr; rdy_in = rdy; flush_in = fl;
        full  = (q.size() == DEPTH);
        empty = (q.size() == 0);
        if (fl) q.delete();
        else if (rdy) begin
            if (!empty && dr) void'(q.pop_front());
            if (v && !full) begin
                e = ref_decode(w);
                e.pc = pc;
                q.push_back(e);
            end
        end
        @(posedge clk_in);
        #1;
        compare_model(tag);
    endtask

    task automatic drain();
        for (int k = 0; k < DEPTH + 1; k++)
            if (q.size() != 0) step("drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    endtask

    function automatic logic [31:0] gen_inst();
        pat_t p;
        if ($urandom_range(0, 4) == 0) return $urandom;
        p = pats[$urandom_range(0, pats.size() - 1)];
        return ($urandom & ~p.mask) | p.match;
    endfunction

    initial begin
        build_table();
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
        inst_valid = 1'b0; inst = '0; inst_pc = '0; dec_ready = 1'b0;
        #1;
        check("reset.inst_ready", 64'(inst_ready), 64'd1);
        check("reset.dec_valid",  64'(dec_valid),  64'd0);
        check("reset.name",       64'(dec_name),   64'd0);
        check("reset.imm",        64'(dec_imm),    64'd0);
        check("reset.pc",         64'(dec_pc),     64'd0);
        check("reset.illegal",    64'(dec_illegal), 64'd0);
        @(posedge clk_in); @(posedge clk_in); #1;
        rst_in = 1'b1;

        // ADDI x1,x0,5 into an empty queue appears at the head the next cycle.
        step("addi", 1'b1, 32'h0050_0093, 32'h0000_1000, 1'b0, 1'b1, 1'b0);
        check("addi.valid", 64'(dec_valid), 64'd1);
        check("addi.name",  64'(dec_name),  64'(NAME_ADDI));
        check("addi.rd",    64'(dec_rd),    64'd1);
        check("addi.rs1",   64'(dec_rs1),   64'd0);
        check("addi.rs2",   64'(dec_rs2),   64'd0);
        check("addi.imm",   64'(dec_imm),   64'd5);
        drain();

        step("beq", 1'b1, 32'hFE00_0EE3, 32'h0000_1004, 1'b0, 1'b1, 1'b0);
        check("beq.name", 64'(dec_name), 64'(NAME_BEQ));
        check("beq.imm",  64'(dec_imm),  64'hFFFF_FFFC);
        check("beq.rd",   64'(dec_rd),   64'd0);
        drain();

        step("sw", 1'b1, 32'h0011_2623, 32'h0000_1008, 1'b0, 1'b1, 1'b0);
        check("sw.name", 64'(dec_name), 64'(NAME_SW));
        check("sw.imm",  64'(dec_imm),  64'd12);
        check("sw.rs1",  64'(dec_rs1),  64'd2);
        check("sw.rs2",  64'(dec_rs2),  64'd1);
        check("sw.rd",   64'(dec_rd),   64'd0);
        drain();

        // Fill to DEPTH (pointers wrap past the earlier three entries).
        for (int k = 0; k < DEPTH; k++)
            step("fill", 1'b1, gen_inst(), 32'h0000_2000 + 32'(k * 4), 1'b0, 1'b1, 1'b0);
        check("full.inst_ready", 64'(inst_ready), 64'd0);
        step("full_deq", 1'b1, 32'h0050_0093, 32'h0000_2100, 1'b1, 1'b1, 1'b0);
        check("full_deq.inst_ready", 64'(inst_ready), 64'd1);
        for (int k = 0; k < 6; k++)
            step("stream", 1'b1, gen_inst(), 32'h0000_2200 + 32'(k * 4), 1'b1, 1'b1, 1'b0);
        drain();

        // Flush with three entries, concurrent enqueue and dequeue: all discarded.
        for (int k = 0; k < 3; k++)
            step("pre_flush", 1'b1, gen_inst(), 32'h0000_3000 + 32'(k * 4), 1'b0, 1'b1, 1'b0);
        step("flush", 1'b1, 32'h0050_0093, 32'h0000_3100, 1'b1, 1'b1, 1'b1);
        check("flush.dec_valid",  64'(dec_valid),  64'd0);
        check("flush.inst_ready", 64'(inst_ready), 64'd1);
        step("post_flush", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
        check("post_flush.dec_valid", 64'(dec_valid), 64'd0);

        step("mul", 1'b1, 32'h0220_8033, 32'h0000_4000, 1'b0, 1'b1, 1'b0);
`ifdef DECODE_RV32M_EN
        check("mul.name",    64'(dec_name),    64'(NAME_MUL));
        check("mul.illegal", 64'(dec_illegal), 64'd0);
`else
        check("mul.name",    64'(dec_name),    64'd0);
        check("mul.illegal", 64'(dec_illegal), 64'd1);
`endif
        step("ones", 1'b1, 32'hFFFF_FFFF, 32'h0000_4004, 1'b1, 1'b1, 1'b0);
        check("ones.illegal", 64'(dec_illegal), 64'd1);
        check("ones.imm",     64'(dec_imm),     64'd0);
        drain();

        // rdy_in low freezes the queue despite valid and ready being offered.
        step("pre_hold", 1'b1, gen_inst(), 32'h0000_5000, 1'b0, 1'b1, 1'b0);
        step("pre_hold", 1'b1, gen_inst(), 32'h0000_5004, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++)
            step("hold", 1'b1, gen_inst(), 32'h0000_5100, 1'b1, 1'b0, 1'b0);
        drain();

        for (int k = 0; k < 400; k++)
            step("rand", ($urandom_range(0, 3) != 0), gen_inst(), $urandom,
                 ($urandom_range(0, 2) != 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 24) == 0));

        // Asynchronous reset mid-stream with entries held.
        for (int k = 0; k < 2; k++)
            step("pre_rst", 1'b1, gen_inst(), 32'h0000_6000 + 32'(k * 4), 1'b0, 1'b1, 1'b0);
        #2;
        rst_in = 1'b0;
        #1;
        q.delete();
        check("async_rst.dec_valid",  64'(dec_valid),  64'd0);
        check("async_rst.inst_ready", 64'(inst_ready), 64'd1);
        check("async_rst.name",       64'(dec_name),   64'd0);
        check("async_rst.pc",         64'(dec_pc),     64'd0);
        check("async_rst.imm",        64'(dec_imm),    64'd0);
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        step("after_rst", 1'b1, 32'h0050_0093, 32'h0000_7000, 1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
